dpram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that sits directly upstream of DualPortRAM and drives it.
//  - Port A is the write port; port B is the read port.
//  - Converts a producer/consumer push/pop interface into RAM addresses, write enables and a read-valid strobe.
//  - DualPortRAM stays a separate instance and is wired to the ram_* ports.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/dpram_fifo_ctrl_if.sv | 38 +++
 rtl/DualPortRAM.sv | 27 ++
 rtl/fifo_ptr.sv | 28 ++
 rtl/dpram_fifo_ctrl.sv | 81 ++++++++
 tb/tb_dpram_fifo_ctrl.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and types for the DualPortRAM FIFO controller.
package fifo_pkg;

  localparam int FIFO_DATA_W   = 8;
  localparam int FIFO_ADDR_W   = 6;
  localparam int FIFO_AF_LEVEL = 56;

  // Pointer with one extra wrap bit above the RAM address.
  typedef logic [FIFO_ADDR_W:0] ptr_t;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer side of the FIFO controller.
//
// Handshake: a push is taken on a rising edge where wr_en=1 and full=0; a pop
// is taken on a rising edge where rd_en=1 and empty=0. Requests made while
// full/empty are dropped and latched into overflow/underflow. rd_valid is a
// one-cycle strobe in the cycle after an accepted pop, qualifying rd_data.
interface dpram_fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              almost_full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  // Producer/consumer view.
  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, rd_valid, empty, count, overflow, underflow
  );

  // Controller view.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, rd_valid, empty, count, overflow, underflow
  );

endinterface

// File: rtl/DualPortRAM.sv
// Simple dual-port RAM with registered (read-old-data) outputs on both ports.
module DualPortRAM #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] input_data_a,
  output logic [DATA_W-1:0] output_data_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] input_data_b,
  output logic [DATA_W-1:0] output_data_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Writes and registered reads on both ports.
  always_ff @(posedge clk) begin
    if (we_a) mem[address_a] <= input_data_a;
    if (we_b) mem[address_b] <= input_data_b;
    output_data_a <= mem[address_a];
    output_data_b <= mem[address_b];
  end

endmodule

// File: rtl/fifo_ptr.sv
// Binary FIFO pointer: RAM address plus a wrap bit that toggles on each lap.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  logic [ADDR_W:0] ptr;

  // Advance on every accepted transfer; natural overflow flips the wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

  assign addr = ptr[ADDR_W-1:0];
  assign wrap = ptr[ADDR_W];

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external DualPortRAM: port A writes, port B reads.
module dpram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  dpram_fifo_ctrl_if.slave  bus,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_b
);

  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);

  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_wrap, rd_wrap;
  logic              push_ok, pop_ok;
  logic              rd_valid_q, overflow_q, underflow_q;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_ok),
    .addr  (wr_addr),
    .wrap  (wr_wrap)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_ok),
    .addr  (rd_addr),
    .wrap  (rd_wrap)
  );

  // Status flags decoded from the registered pointers only.
  always_comb begin
    bus.empty       = (wr_addr == rd_addr) && (wr_wrap == rd_wrap);
    bus.full        = (wr_addr == rd_addr) && (wr_wrap != rd_wrap);
    bus.count       = {wr_wrap, wr_addr} - {rd_wrap, rd_addr};
    bus.almost_full = (bus.count >= AF_CNT);
  end

  assign push_ok = bus.wr_en & ~bus.full;
  assign pop_ok  = bus.rd_en & ~bus.empty;

  // Port A writes the accepted push; port B only ever reads.
  assign ram_we_a   = push_ok;
  assign ram_addr_a = wr_addr;
  assign ram_din_a  = bus.wr_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_addr;
  assign ram_din_b  = '0;

  // Read strobe lines up with the RAM's registered output; errors are sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_q  <= pop_ok;
      overflow_q  <= overflow_q  | (bus.wr_en & bus.full);
      underflow_q <= underflow_q | (bus.rd_en & bus.empty);
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = ram_dout_b;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl wired to a DualPortRAM instance.
module tb_dpram_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 6;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;

  dpram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(56)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_din_b  (ram_din_b),
    .ram_dout_b (ram_dout_b)
  );

  DualPortRAM #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
    .clk           (clk),
    .we_a          (ram_we_a),
    .address_a     (ram_addr_a),
    .input_data_a  (ram_din_a),
    .output_data_a (ram_dout_a),
    .we_b          (ram_we_b),
    .address_b     (ram_addr_b),
    .input_data_b  (ram_din_b),
    .output_data_b (ram_dout_b)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs mid-cycle, then let combinational outputs settle.
  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    #1;
  endtask

  // Advance through one rising edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] k;
    logic [DW-1:0] popped;
    logic [AW-1:0] prev_addr;
    int first_af;
    bit saw_wrap;

    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;
    tick();
    tick();
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_af", 32'(bus.almost_full), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_underflow", 32'(bus.underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single push then pop
    drive(1'b1, 8'hAA, 1'b0);
    chk("push_we_a", 32'(ram_we_a), 1);
    chk("push_addr_a", 32'(ram_addr_a), 0);
    chk("push_din_a", 32'(ram_din_a), 32'hAA);
    chk("ram_we_b_tied", 32'(ram_we_b), 0);
    tick();
    chk("push_count", 32'(bus.count), 1);
    chk("push_empty", 32'(bus.empty), 0);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    chk("pop_rd_valid", 32'(bus.rd_valid), 1);
    chk("pop_rd_data", 32'(bus.rd_data), 32'hAA);
    chk("pop_count", 32'(bus.count), 0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("pop_strobe_one_cycle", 32'(bus.rd_valid), 0);

    // Fill 64 words
    first_af = -1;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 56));
      if (bus.almost_full && first_af < 0) first_af = int'(bus.count);
    end
    chk("af_first_level", 32'(first_af), 56);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_overflow_clear", 32'(bus.overflow), 0);
    drive(1'b1, 8'hEE, 1'b0);
    chk("ovf_we_a", 32'(ram_we_a), 0);
    tick();
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 64);

    // Drain all 64
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      tick();
      chk("drain_rd_valid", 32'(bus.rd_valid), 1);
      chk("drain_rd_data", 32'(bus.rd_data), 32'(i));
      chk("drain_count", 32'(bus.count), 32'(63 - i));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_underflow_clear", 32'(bus.underflow), 0);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    chk("udf_flag", 32'(bus.underflow), 1);
    chk("udf_rd_valid", 32'(bus.rd_valid), 0);
    chk("udf_count", 32'(bus.count), 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);

    // Streaming with wrap
    k = 8'h80;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, k, 1'b0);
      exp_q.push_back(k);
      k++;
      tick();
    end
    prev_addr = ram_addr_a;
    saw_wrap = 1'b0;
    for (int j = 0; j < 100; j++) begin
      drive(1'b1, k, 1'b1);
      if (prev_addr == 6'd63 && ram_addr_a == 6'd0) saw_wrap = 1'b1;
      prev_addr = ram_addr_a;
      exp_q.push_back(k);
      k++;
      popped = exp_q.pop_front();
      tick();
      chk("stream_count", 32'(bus.count), 3);
      chk("stream_full", 32'(bus.full), 0);
      chk("stream_rd_valid", 32'(bus.rd_valid), 1);
      chk("stream_rd_data", 32'(bus.rd_data), 32'(popped));
    end
    chk("stream_addr_wrap", 32'(saw_wrap), 1);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 8'h00, 1'b1);
      popped = exp_q.pop_front();
      tick();
      chk("stream_tail_data", 32'(bus.rd_data), 32'(popped));
    end
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("stream_empty", 32'(bus.empty), 1);

    // Push+pop while empty
    drive(1'b1, 8'h5A, 1'b1);
    chk("pp_empty_we_a", 32'(ram_we_a), 1);
    tick();
    chk("pp_empty_count", 32'(bus.count), 1);
    chk("pp_empty_rd_valid", 32'(bus.rd_valid), 0);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    chk("pp_empty_data", 32'(bus.rd_data), 32'h5A);
    chk("pp_empty_valid", 32'(bus.rd_valid), 1);

    // Push+pop while full
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 8'(i + 8'h40), 1'b0);
      tick();
    end
    chk("pp_full_full", 32'(bus.full), 1);
    drive(1'b1, 8'hFF, 1'b1);
    chk("pp_full_we_a", 32'(ram_we_a), 0);
    tick();
    chk("pp_full_count", 32'(bus.count), 63);
    chk("pp_full_overflow", 32'(bus.overflow), 1);
    chk("pp_full_rd_valid", 32'(bus.rd_valid), 1);
    chk("pp_full_rd_data", 32'(bus.rd_data), 32'h40);

    // Asynchronous reset mid-stream, checked before the next rising edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_rd_valid", 32'(bus.rd_valid), 0);
    chk("arst_overflow", 32'(bus.overflow), 0);
    chk("arst_underflow", 32'(bus.underflow), 0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", 32'(bus.empty), 1);
    chk("post_rst_addr_a", 32'(ram_addr_a), 0);

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
